// File: rtl/ysyx_22050518_pkg.sv
// Shared definitions for the core memory-port arbiter.
// Holds the arbiter FSM state encoding and the owner encoding.
// No logic; imported by ysyx_22050518_mem_arb.
package ysyx_22050518_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22050518_mem_arb.sv
// Purpose : arbitrates the single core memory port between IFU and LSU,
//           one outstanding transaction, LSU has fixed priority, no preemption.
// Latency : accept at N, mem_req_valid at N+1, earliest response at N+2,
//           next accept at N+3.
// Backpressure : request readies are only offered in IDLE; a downstream request
//           is held stable until mem_req_ready, and the response is waited for.
// Ports :
//   clk, rst_n (synchronous, active-low)
//   ifu_req_valid/ifu_req_ready/ifu_addr/ifu_flush, ifu_rsp_valid/ifu_rsp_data
//   lsu_req_valid/lsu_req_ready/lsu_addr/lsu_wen/lsu_wdata/lsu_wmask,
//   lsu_rsp_valid/lsu_rsp_data
//   mem_req_valid/mem_req_ready/mem_addr/mem_wen/mem_wdata/mem_wmask,
//   mem_rsp_valid/mem_rsp_data, busy
module ysyx_22050518_mem_arb
  import ysyx_22050518_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  input  logic            ifu_flush,
  output logic            ifu_rsp_valid,
  output logic [DW-1:0]   ifu_rsp_data,

  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_rsp_valid,
  output logic [DW-1:0]   lsu_rsp_data,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_data,

  output logic            busy
);

  arb_state_e          state_q, state_d;
  logic                owner_q;
  logic                drop_q, drop_d;
  logic [AW-1:0]       addr_q;
  logic                wen_q;
  logic [DW-1:0]       wdata_q;
  logic [DW/8-1:0]     wmask_q;

  logic                load_lsu;
  logic                load_ifu;

  // Next state, handshakes and response steering.
  // Handshake outputs are masked while rst_n is low so nothing is accepted
  // or returned on the reset edge.
  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    load_lsu      = 1'b0;
    load_ifu      = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (lsu_req_valid) begin
          lsu_req_ready = rst_n;
          load_lsu      = 1'b1;
          state_d       = ARB_REQ;
        end else if (ifu_req_valid && !ifu_flush) begin
          ifu_req_ready = rst_n;
          load_ifu      = 1'b1;
          state_d       = ARB_REQ;
        end
      end

      ARB_REQ: begin
        // The request stays up even if a flush arrives; the bridge has
        // already seen it and must be allowed to complete.
        mem_req_valid = rst_n;
        if (mem_req_ready) begin
          state_d = ARB_RSP;
        end
        if (ifu_flush && owner_q == OWN_IFU) begin
          drop_d = 1'b1;
        end
      end

      ARB_RSP: begin
        if (ifu_flush && owner_q == OWN_IFU) begin
          drop_d = 1'b1;
        end
        if (mem_rsp_valid) begin
          state_d = ARB_IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_rsp_valid = rst_n;
          end else begin
            // A flush in the response cycle itself also kills the fetch.
            ifu_rsp_valid = rst_n && !drop_q && !ifu_flush;
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // Every return to IDLE starts the next transaction with a clean flag.
    if (state_d == ARB_IDLE) begin
      drop_d = 1'b0;
    end
  end

  // FSM state and request register share one process so the captured
  // fields can never disagree with the state that owns them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IFU;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (load_lsu) begin
        owner_q <= OWN_LSU;
        addr_q  <= lsu_addr;
        wen_q   <= lsu_wen;
        wdata_q <= lsu_wdata;
        wmask_q <= lsu_wmask;
      end else if (load_ifu) begin
        owner_q <= OWN_IFU;
        addr_q  <= ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end
    end
  end

  assign mem_addr     = addr_q;
  assign mem_wen      = wen_q;
  assign mem_wdata    = wdata_q;
  assign mem_wmask    = wmask_q;

  assign ifu_rsp_data = mem_rsp_data;
  assign lsu_rsp_data = mem_rsp_data;

  assign busy         = (state_q != ARB_IDLE);

endmodule
